// File: rtl/alu_pkg.sv
// Shared constants for the ALU flag stage: flag bit positions, skid states,
// and the condition-code derivation applied when a sum is loaded.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam int FLAG_OF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_NF = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } skid_st_e;

  // Returns {eq, lt, ge, ltu}; ltu=~cf assumes subtract was done as a+~b+1.
  function automatic logic [3:0] cond_codes(input logic [3:0] flags);
    logic lt;
    lt = flags[FLAG_NF] ^ flags[FLAG_OF];
    return {flags[FLAG_ZF], lt, ~lt, ~flags[FLAG_CF]};
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready is a flop, so there is no
// combinational path from out_ready back to in_ready.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_st_e      state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          rdy_q;
  logic          accept, emit;

  assign accept    = in_valid & rdy_q;
  assign emit      = (state_q != S_EMPTY) & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != S_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_d  = in_data;
        end
      end
      S_ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = S_FULL;
          skid_d  = in_data;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // Older entry sits in main, so skid only ever moves forward into it.
        if (emit) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage behind sign_adder: skid-buffered payload plus
// sticky of/cf status, saturating transfer counter and a flag sanity check.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_result,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       out_cond,
  output logic             flag_err,
  input  logic             sticky_clr,
  output logic             sticky_of,
  output logic             sticky_cf,
  output logic [CNT_W-1:0] op_count
);

  localparam int DW = W + 8;

  logic [DW-1:0]    pl_in, pl_out;
  logic             accept, emit;
  logic             sof_q, sof_d, scf_q, scf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Condition codes are resolved on the way in so they travel with the sum.
  assign pl_in = {in_result, in_flags, cond_codes(in_flags)};

  alu_skid_buf #(.DW(DW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pl_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pl_out)
  );

  assign out_result = pl_out[DW-1 -: W];
  assign out_flags  = pl_out[7:4];
  assign out_cond   = pl_out[3:0];

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // of and cf cannot be cross-checked without the operands, so only zf/nf are.
  assign flag_err = out_valid &
                    ((out_flags[FLAG_ZF] != (out_result == '0)) |
                     (out_flags[FLAG_NF] != out_result[W-1]));

  always_comb begin
    sof_d = (sof_q & ~sticky_clr) | (accept & in_flags[FLAG_OF]);
    scf_d = (scf_q & ~sticky_clr) | (accept & in_flags[FLAG_CF]);
    cnt_d = cnt_q;
    if (emit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_q <= 1'b0;
      scf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sof_q <= sof_d;
      scf_q <= scf_d;
      cnt_q <= cnt_d;
    end
  end

  assign sticky_of = sof_q;
  assign sticky_cf = scf_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a queue-based reference model.
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_result, out_result;
  logic [3:0]  in_flags, out_flags, out_cond;
  logic        flag_err, sticky_clr, sticky_of, sticky_cf;
  logic [15:0] op_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_out_result;
  logic [3:0]  s_out_flags, s_out_cond;
  logic        s_flag_err, s_sof, s_scf;
  logic [3:0]  s_op_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_flag_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_cond(out_cond),
    .flag_err(flag_err), .sticky_clr(sticky_clr),
    .sticky_of(sticky_of), .sticky_cf(sticky_cf), .op_count(op_count)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  alu_flag_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_result(32'd7), .in_flags(4'b0000),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_flags(s_out_flags), .out_cond(s_out_cond),
    .flag_err(s_flag_err), .sticky_clr(1'b0),
    .sticky_of(s_sof), .sticky_cf(s_scf), .op_count(s_op_count)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference semantics: signed/unsigned compare outcomes from adder flags.
  function automatic logic [3:0] ref_cond(input logic [3:0] f);
    bit eq, lt_s, lt_u;
    eq   = f[1];
    lt_s = (f[0] != f[3]);
    lt_u = (f[2] == 1'b0);
    return {eq, lt_s, !lt_s, lt_u};
  endfunction

  function automatic bit ref_err(input logic [31:0] r, input logic [3:0] f);
    return (f[1] != (r == 32'd0)) || (f[0] != ($signed(r) < 0));
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  cond;
    bit          err;
    bit          sof;
    bit          scf;
  } vec_t;

  vec_t vt[5];

  logic [35:0] mq[$];
  int unsigned mcnt;
  bit msof, mscf, acc, emt;
  logic [31:0] r;
  logic [3:0]  f;

  initial begin
    rst = 1'b1; in_valid = 0; in_result = '0; in_flags = '0;
    out_ready = 1'b1; sticky_clr = 0; s_in_valid = 0; s_out_ready = 1'b1;

    vt[0] = '{32'h8000_0000, 4'b1001, 4'b0011, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0000, 4'b0110, 4'b1010, 1'b0, 1'b1, 1'b1};
    vt[2] = '{32'hFFFF_FFFB, 4'b0001, 4'b0101, 1'b0, 1'b1, 1'b1};
    vt[3] = '{32'h0000_0005, 4'b0010, 4'b1011, 1'b1, 1'b1, 1'b1};
    vt[4] = '{32'h1234_5678, 4'b0001, 4'b0101, 1'b1, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_sticky", {sticky_of, sticky_cf, flag_err}, 0);
    chk("rst_outputs", {out_result, out_flags, out_cond}, 0);
    rst = 1'b0;

    // Directed vectors, one op at a time with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; in_result = vt[i].res; in_flags = vt[i].flags;
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), out_result, vt[i].res);
      chk($sformatf("vec%0d_flags", i), out_flags, vt[i].flags);
      chk($sformatf("vec%0d_cond", i), out_cond, vt[i].cond);
      chk($sformatf("vec%0d_cond_ref", i), out_cond, ref_cond(vt[i].flags));
      chk($sformatf("vec%0d_flag_err", i), flag_err, vt[i].err);
      chk($sformatf("vec%0d_sticky", i), {sticky_of, sticky_cf}, {vt[i].sof, vt[i].scf});
      @(negedge clk);
      chk($sformatf("vec%0d_op_count", i), op_count, i + 1);
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Backpressure: A, B accepted; C refused while full.
    out_ready = 0; in_valid = 1; in_result = 32'hA; in_flags = 4'b0000;
    @(negedge clk);
    chk("bp_ready_after_a", in_ready, 1);
    chk("bp_out_a", out_result, 32'hA);
    in_result = 32'hB;
    @(negedge clk);
    chk("bp_ready_full", in_ready, 0);
    in_result = 32'hC;
    @(negedge clk);
    chk("bp_still_full", in_ready, 0);
    chk("bp_hold_a", {out_valid, out_result}, {1'b1, 32'hA});
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp_out_b", {out_valid, out_result}, {1'b1, 32'hB});
    chk("bp_ready_again", in_ready, 1);
    @(negedge clk);
    chk("bp_empty_no_c", out_valid, 0);
    chk("bp_op_count", op_count, 7);

    // Sticky clear: set wins over clear in the same cycle.
    sticky_clr = 1;
    @(negedge clk);
    chk("stk_cleared", {sticky_of, sticky_cf}, 0);
    in_valid = 1; in_result = 32'h8000_0000; in_flags = 4'b1001;
    @(negedge clk);
    chk("stk_set_wins", sticky_of, 1);
    in_valid = 0;
    @(negedge clk);
    chk("stk_clr_alone", sticky_of, 0);
    sticky_clr = 0;

    // Inconsistent flags held under backpressure.
    out_ready = 0; in_valid = 1; in_result = 32'd5; in_flags = 4'b0010;
    @(negedge clk);
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ferr_hold%0d", k), {flag_err, out_result}, {1'b1, 32'd5});
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("ferr_gone", {out_valid, flag_err}, 0);

    // Reset while FULL.
    out_ready = 0; in_valid = 1; in_result = 32'h111; in_flags = 4'b1100;
    @(negedge clk);
    in_result = 32'h222;
    @(negedge clk);
    in_valid = 0;
    chk("rf_full", in_ready, 0);
    #1 rst = 1;
    #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_in_ready", in_ready, 1);
    chk("rf_clean", {out_result, sticky_of, sticky_cf, op_count}, 0);
    @(negedge clk);
    rst = 0; out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rf_no_stale", out_valid, 0);
    end

    // Randomized run against a FIFO-of-two model.
    mq.delete(); mcnt = 0; msof = 0; mscf = 0;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_in_ready", in_ready, mq.size() < 2);
      chk("rnd_out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_result", out_result, mq[0][35:4]);
        chk("rnd_flags", out_flags, mq[0][3:0]);
        chk("rnd_cond", out_cond, ref_cond(mq[0][3:0]));
        chk("rnd_flag_err", flag_err, ref_err(mq[0][35:4], mq[0][3:0]));
      end else begin
        chk("rnd_flag_err_idle", flag_err, 0);
      end
      chk("rnd_sticky", {sticky_of, sticky_cf}, {msof, mscf});
      chk("rnd_op_count", op_count, mcnt);

      case ($urandom_range(0, 7))
        0:       r = 32'd0;
        1:       r = 32'h8000_0000;
        2:       r = 32'h7FFF_FFFF;
        default: r = $urandom;
      endcase
      f = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, r == 32'd0, r[31]};
      if ($urandom_range(0, 7) == 0) f = 4'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      in_result  = r; in_flags = f;
      acc = in_valid && (mq.size() < 2);
      emt = out_ready && (mq.size() > 0);
      @(negedge clk);
      if (emt) begin
        void'(mq.pop_front());
        if (mcnt < 65535) mcnt++;
      end
      msof = (msof && !sticky_clr) || (acc && f[3]);
      mscf = (mscf && !sticky_clr) || (acc && f[2]);
      if (acc) mq.push_back({r, f});
    end
    in_valid = 0; sticky_clr = 0;

    // Saturation on the 4-bit counter instance: 15 must hold, not wrap.
    s_in_valid = 1;
    repeat (25) @(negedge clk);
    chk("sat_at_max", s_op_count, 4'd15);
    chk("sat_emitting", s_out_valid, 1);
    @(negedge clk);
    chk("sat_holds", s_op_count, 4'd15);
    s_in_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
